// File: rtl/mod_dst_fifo.sv
// mod_dst_fifo: destination-side receiver for the data-mover operation interface.
// Buffers 64-bit result words plus a last marker in a 2^AW entry register FIFO,
// drives full/almost-full back-pressure to the engines, presents a
// first-word-fall-through read port to the write-back DMA and reports
// operation completion once all words of an ended operation have drained.
//
// Ports:
//   wb_clk_i          clock
//   wb_rst_n          synchronous active-low reset
//   m_dst_putn        active-low write strobe from the engine
//   m_dst, m_dst_last write data and last-of-operation marker
//   m_endn            active-low one-cycle end-of-operation strobe
//   m_dst_full        no free entries
//   m_dst_almost_full free entries <= AF_MARGIN
//   d_getn            active-low pop from the write-back DMA
//   d_data, d_last    head entry (valid while d_empty = 0)
//   d_empty           no stored entries
//   d_almost_empty    stored entries <= AE_MARGIN
//   d_level           stored entry count
//   op_done           one-cycle completion pulse
//   op_words          words accepted for the completed operation
//   err_ovf/unf/proto sticky error flags
module mod_dst_fifo #(
  parameter int unsigned AW        = 4,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned AE_MARGIN = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          m_dst_putn,
  input  logic [63:0]   m_dst,
  input  logic          m_dst_last,
  input  logic          m_endn,
  output logic          m_dst_full,
  output logic          m_dst_almost_full,
  input  logic          d_getn,
  output logic [63:0]   d_data,
  output logic          d_last,
  output logic          d_empty,
  output logic          d_almost_empty,
  output logic [AW:0]   d_level,
  output logic          op_done,
  output logic [23:0]   op_words,
  output logic          err_ovf,
  output logic          err_unf,
  output logic          err_proto
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] DepthL = (AW + 1)'(Depth);
  localparam logic [AW:0] AfThr  = (AW + 1)'(Depth - AF_MARGIN);
  localparam logic [AW:0] AeThr  = (AW + 1)'(AE_MARGIN);

  // Storage: {last, data}
  logic [64:0]   mem_q [Depth];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, afull_q, empty_q, aempty_q;

  logic [23:0]   wcnt_q, wcnt_inc, words_q;
  logic          end_pend_q, op_done_q, last_seen_q;
  logic          err_ovf_q, err_unf_q, err_proto_q;

  logic          wr, rd, end_req, done_fire, last_eff, proto_hit;

  always_comb begin
    wr        = !m_dst_putn && !full_q;
    rd        = !d_getn && !empty_q;
    end_req   = !m_endn;
    // Completion waits for the DMA to drain everything and for the engine to
    // be quiet, so a follow-on operation's first word cannot race the pulse.
    done_fire = end_pend_q && empty_q && !wr;
    // A write accepted in the same cycle as the end strobe is the most recent.
    last_eff  = wr ? m_dst_last : last_seen_q;
    proto_hit = end_req && (end_pend_q || !last_eff);
    wcnt_inc  = wcnt_q + {23'd0, wr};

    count_d = count_q;
    if (wr && !rd) begin
      count_d = count_q + 1'b1;
    end else if (rd && !wr) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_n && wr) begin
      mem_q[wptr_q] <= {m_dst_last, m_dst};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      wcnt_q      <= '0;
      words_q     <= '0;
      end_pend_q  <= 1'b0;
      op_done_q   <= 1'b0;
      last_seen_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      if (wr) begin
        wptr_q      <= wptr_q + 1'b1;
        last_seen_q <= m_dst_last;
      end
      if (rd) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q  <= count_d;
      // Flags registered from the next count so they line up with d_level.
      full_q   <= (count_d == DepthL);
      afull_q  <= (count_d >= AfThr);
      empty_q  <= (count_d == '0);
      aempty_q <= (count_d <= AeThr);

      if (!m_dst_putn && full_q) begin
        err_ovf_q <= 1'b1;
      end
      if (!d_getn && empty_q) begin
        err_unf_q <= 1'b1;
      end
      if (proto_hit) begin
        err_proto_q <= 1'b1;
      end

      if (end_req) begin
        words_q <= wcnt_inc;
        wcnt_q  <= '0;
      end else begin
        wcnt_q  <= wcnt_inc;
      end

      op_done_q <= done_fire;
      // A new end strobe re-arms tracking even if the old one completes now.
      if (end_req) begin
        end_pend_q <= 1'b1;
      end else if (done_fire) begin
        end_pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    m_dst_full        = full_q;
    m_dst_almost_full = afull_q;
    d_empty           = empty_q;
    d_almost_empty    = aempty_q;
    d_level           = count_q;
    // Head is forced to zero while empty so reset and drained states read 0.
    d_data            = empty_q ? 64'd0 : mem_q[rptr_q][63:0];
    d_last            = empty_q ? 1'b0 : mem_q[rptr_q][64];
    op_done           = op_done_q;
    op_words          = words_q;
    err_ovf           = err_ovf_q;
    err_unf           = err_unf_q;
    err_proto         = err_proto_q;
  end

endmodule

// File: tb/tb_mod_dst_fifo.sv
module tb_mod_dst_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        putn = 1'b1, last = 1'b0, endn = 1'b1, getn = 1'b1;
  logic [63:0] dat = '0;

  logic        full, afull, d_last, d_empty, d_aempty, op_done, e_ovf, e_unf, e_proto;
  logic [63:0] d_data;
  logic [4:0]  d_level;
  logic [23:0] op_words;

  mod_dst_fifo dut (
    .wb_clk_i          (clk),
    .wb_rst_n          (rst_n),
    .m_dst_putn        (putn),
    .m_dst             (dat),
    .m_dst_last        (last),
    .m_endn            (endn),
    .m_dst_full        (full),
    .m_dst_almost_full (afull),
    .d_getn            (getn),
    .d_data            (d_data),
    .d_last            (d_last),
    .d_empty           (d_empty),
    .d_almost_empty    (d_aempty),
    .d_level           (d_level),
    .op_done           (op_done),
    .op_words          (op_words),
    .err_ovf           (e_ovf),
    .err_unf           (e_unf),
    .err_proto         (e_proto)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a queue of {last,data} plus the completion rules.
  logic [64:0] q[$];
  bit          m_ovf = 0, m_unf = 0, m_proto = 0, m_pend = 0, m_done = 0, m_lastw = 0;
  logic [23:0] m_wcnt = '0, m_words = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_proto = 0; m_pend = 0; m_done = 0; m_lastw = 0;
      m_wcnt = '0; m_words = '0;
    end else begin
      int  n;
      bit  w, r, e, fire, le;
      n    = q.size();
      w    = !putn && (n < 16);
      r    = !getn && (n > 0);
      e    = !endn;
      fire = m_pend && (n == 0) && !w;
      if (!putn && n == 16) m_ovf = 1;
      if (!getn && n == 0) m_unf = 1;
      le = w ? last : m_lastw;
      if (e) begin
        if (m_pend || !le) m_proto = 1;
        m_words = m_wcnt + 24'(w);
        m_wcnt  = '0;
      end else begin
        m_wcnt = m_wcnt + 24'(w);
      end
      if (r) void'(q.pop_front());
      if (w) begin
        q.push_back({last, dat});
        m_lastw = last;
      end
      m_pend = e ? 1'b1 : (fire ? 1'b0 : m_pend);
      m_done = fire;
    end
  end

  always @(posedge clk) begin
    int n;
    #1;
    n = q.size();
    chk("level", 64'(d_level), 64'(n));
    chk("full", 64'(full), 64'(n == 16));
    chk("almost_full", 64'(afull), 64'(n >= 14));
    chk("empty", 64'(d_empty), 64'(n == 0));
    chk("almost_empty", 64'(d_aempty), 64'(n <= 1));
    chk("op_done", 64'(op_done), 64'(m_done));
    chk("op_words", 64'(op_words), 64'(m_words));
    chk("err_ovf", 64'(e_ovf), 64'(m_ovf));
    chk("err_unf", 64'(e_unf), 64'(m_unf));
    chk("err_proto", 64'(e_proto), 64'(m_proto));
    if (n > 0) begin
      chk("d_data", d_data, q[0][63:0]);
      chk("d_last", 64'(d_last), 64'(q[0][64]));
    end
    if (op_done === 1'b1) done_cnt++;
  end

  // One cycle of stimulus, applied at the falling edge.
  task automatic cyc(input bit p, input logic [63:0] d, input bit l, input bit e, input bit g);
    @(negedge clk);
    putn = !p; dat = d; last = l; endn = !e; getn = !g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; putn = 1'b1; endn = 1'b1; getn = 1'b1; last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a0, a1, a2;
    a0 = 64'hA0A0_0000_0000_0001;
    a1 = 64'hA1A1_0000_0000_0002;
    a2 = 64'hA2A2_0000_0000_0003;

    // Reset state and a 3-word operation.
    do_reset();
    chk("rst empty", 64'(d_empty), 64'd1);
    chk("rst level", 64'(d_level), 64'd0);
    chk("rst data", d_data, 64'd0);
    cyc(1, a0, 0, 0, 0);
    cyc(1, a1, 0, 0, 0);
    cyc(1, a2, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 0, 0);
    chk("head a0", d_data, a0);
    chk("op_words 3", 64'(op_words), 64'd3);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0, 1);
    idle(4);
    chk("done once", 64'(done_cnt), 64'd1);

    // Fill to 16, overflow, then stream with wrap.
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 64'(100 + i), 0, 0, 0);
      @(posedge clk); #1;
      chk("af ramp", 64'(afull), 64'(i >= 14));
      chk("full ramp", 64'(full), 64'(i == 16));
    end
    cyc(1, 64'd999, 0, 0, 0);
    cyc(0, '0, 0, 0, 0);
    chk("ovf", 64'(e_ovf), 64'd1);
    chk("level 16", 64'(d_level), 64'd16);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 64'(200 + i), 0, 0, 1);
      @(posedge clk); #1;
      chk("stream level", 64'(d_level == 15 || d_level == 16), 64'd1);
    end
    for (int i = 0; i < 18; i++) cyc(0, '0, 0, 0, 1);
    idle(2);

    // Underflow and protocol errors.
    do_reset();
    cyc(0, '0, 0, 0, 1);
    idle(1);
    chk("unf", 64'(e_unf), 64'd1);
    chk("unf level", 64'(d_level), 64'd0);
    cyc(0, '0, 0, 1, 0);
    idle(1);
    chk("proto nolast", 64'(e_proto), 64'd1);
    do_reset();
    cyc(1, 64'h55, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    idle(1);
    chk("proto double", 64'(e_proto), 64'd1);

    // Reset during a pending operation.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 64'(300 + i), i == 4, 0, 0);
    cyc(0, '0, 0, 1, 0);
    do_reset();
    done_cnt = 0;
    chk("rst2 empty", 64'(d_empty), 64'd1);
    chk("rst2 level", 64'(d_level), 64'd0);
    cyc(1, 64'h77, 0, 0, 0);
    cyc(1, 64'h78, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    idle(2);
    chk("no stale done", 64'(done_cnt), 64'd0);
    chk("op_words 2", 64'(op_words), 64'd2);
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    idle(3);
    chk("done 2word", 64'(done_cnt), 64'd1);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 599) != 0);
      putn  = ($urandom_range(0, 9) < 4);
      getn  = ($urandom_range(0, 9) < 5);
      last  = ($urandom_range(0, 3) == 0);
      endn  = ($urandom_range(0, 19) != 0);
      dat   = {$urandom, $urandom};
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
